// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory bus arbiter: FSM states, grant owner
// and the fetch lane mask.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_INSTR = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    localparam logic [3:0] FULL_BYTEENABLE = 4'b1111;

endpackage

// File: rtl/mem_arb_timeout.sv
// Stall watchdog for one bus transfer: counts consecutive waitrequest cycles and
// flags expiry on the cycle that would reach TIMEOUT_CYCLES.
module mem_arb_timeout
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_enable,
    input  logic clear,
    input  logic stall,
    output logic expired
);

    logic [15:0] stall_count;

    // Expiry is seen while the last tolerated stall cycle is being counted, so the
    // strobe is dropped at the same edge the count would reach the limit.
    assign expired = stall && (stall_count == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= 16'd0;
        end else if (clk_enable) begin
            if (clear) begin
                stall_count <= 16'd0;
            end else if (stall) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between instruction fetch and data port.
// Optional stall timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        i_req,
    input  logic [31:0] i_address,
    output logic        i_ack,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic        d_ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest
);

    arb_state_t state;
    grant_t     grant;
    grant_t     last_grant;
    grant_t     next_grant;
    logic       d_pending;
    logic       any_req;

    assign d_pending = d_read || d_write;
    assign any_req   = i_req || d_pending;

    // On a tie the requester that did not win last time gets the bus.
    always_comb begin
        next_grant = GNT_DATA;
        if (i_req && d_pending) begin
            next_grant = (last_grant == GNT_INSTR) ? GNT_DATA : GNT_INSTR;
        end else if (i_req) begin
            next_grant = GNT_INSTR;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic timeout_hit;

    mem_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .clear      ((state == IDLE) && any_req),
        .stall      ((state == XFER) && mem_waitrequest),
        .expired    (timeout_hit)
    );
`else
    logic [15:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 16'(TIMEOUT_CYCLES);
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            grant          <= GNT_INSTR;
            last_grant     <= GNT_DATA;
            i_ack          <= 1'b0;
            d_ack          <= 1'b0;
            rdata          <= 32'd0;
            mem_address    <= 32'd0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= 32'd0;
            mem_byteenable <= 4'd0;
`ifdef MEM_ARB_TIMEOUT_EN
            err            <= 1'b0;
`endif
        end else if (clk_enable) begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        state      <= XFER;
                        if (next_grant == GNT_INSTR) begin
                            mem_address    <= i_address;
                            mem_writedata  <= 32'd0;
                            mem_byteenable <= FULL_BYTEENABLE;
                            mem_read       <= 1'b1;
                            mem_write      <= 1'b0;
                        end else begin
                            // A simultaneous read and write is treated as a write.
                            mem_address    <= d_address;
                            mem_writedata  <= d_writedata;
                            mem_byteenable <= d_byteenable;
                            mem_read       <= !d_write;
                            mem_write      <= d_write;
                        end
                    end
                end
                XFER: begin
                    if (!mem_waitrequest) begin
                        if (mem_read) begin
                            rdata <= mem_readdata;
                        end
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        i_ack     <= (grant == GNT_INSTR);
                        d_ack     <= (grant == GNT_DATA);
                        state     <= RESP;
`ifdef MEM_ARB_TIMEOUT_EN
                        err       <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata     <= 32'd0;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        i_ack     <= (grant == GNT_INSTR);
                        d_ack     <= (grant == GNT_DATA);
                        err       <= 1'b1;
                        state     <= RESP;
`endif
                    end
                end
                RESP: begin
                    state <= IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
                    err   <= 1'b0;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; the stall-timeout vector runs only
// when MEM_ARB_TIMEOUT_EN is defined, otherwise an indefinite stall is checked.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        i_req;
    logic [31:0] i_address;
    logic        i_ack;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic        d_ack;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .clk_enable      (clk_enable),
        .i_req           (i_req),
        .i_address       (i_address),
        .i_ack           (i_ack),
        .d_read          (d_read),
        .d_write         (d_write),
        .d_address       (d_address),
        .d_writedata     (d_writedata),
        .d_byteenable    (d_byteenable),
        .d_ack           (d_ack),
        .rdata           (rdata),
        .err             (err),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_byteenable  (mem_byteenable),
        .mem_readdata    (mem_readdata),
        .mem_waitrequest (mem_waitrequest)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dr, input logic dw, input logic [31:0] daddr,
                                 input logic [31:0] dwdata, input logic [3:0] dbe);
        i_req        = ireq;
        i_address    = iaddr;
        d_read       = dr;
        d_write      = dw;
        d_address    = daddr;
        d_writedata  = dwdata;
        d_byteenable = dbe;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_acks"}, {30'd0, i_ack, d_ack}, 32'd0);
        checkOutput({tag, "_strobes"}, {29'd0, mem_read, mem_write, err}, 32'd0);
        checkOutput({tag, "_addr"}, mem_address, 32'd0);
        checkOutput({tag, "_wdata"}, mem_writedata, 32'd0);
        checkOutput({tag, "_be"}, {28'd0, mem_byteenable}, 32'd0);
        checkOutput({tag, "_rdata"}, rdata, 32'd0);
    endtask

    initial begin
        reset           = 1'b1;
        clk_enable      = 1'b1;
        mem_readdata    = 32'd0;
        mem_waitrequest = 1'b0;
        idleInputs();
        tick();
        tick();
        checkAllZero("reset");
        reset = 1'b0;
        tick();

        // Single fetch, no stall: strobe for one cycle, ack two cycles after request.
        $display("[TB] fetch without stall");
        applyStimulus(1'b1, 32'hBFC00000, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        mem_readdata = 32'h24020005;
        tick();
        checkOutput("fetch_read", {31'd0, mem_read}, 32'd1);
        checkOutput("fetch_write", {31'd0, mem_write}, 32'd0);
        checkOutput("fetch_addr", mem_address, 32'hBFC00000);
        checkOutput("fetch_be", {28'd0, mem_byteenable}, 32'hF);
        checkOutput("fetch_early_ack", {31'd0, i_ack}, 32'd0);
        tick();
        checkOutput("fetch_ack", {30'd0, i_ack, d_ack}, 32'd2);
        checkOutput("fetch_rdata", rdata, 32'h24020005);
        checkOutput("fetch_err", {31'd0, err}, 32'd0);
        checkOutput("fetch_strobe_drop", {31'd0, mem_read}, 32'd0);
        idleInputs();
        tick();
        checkOutput("fetch_ack_pulse", {31'd0, i_ack}, 32'd0);

        // Store with three stall cycles; payload must survive a changing requester.
        $display("[TB] store with stalls");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h00000010, 32'hDEADBEEF, 4'b0011);
        mem_waitrequest = 1'b1;
        mem_readdata    = 32'h55555555;
        tick();
        d_writedata  = 32'h01234567;
        d_address    = 32'h00000020;
        d_byteenable = 4'b1100;
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("store_write_%0d", i), {30'd0, mem_write, mem_read}, 32'd2);
            checkOutput($sformatf("store_addr_%0d", i), mem_address, 32'h00000010);
            checkOutput($sformatf("store_wdata_%0d", i), mem_writedata, 32'hDEADBEEF);
            checkOutput($sformatf("store_be_%0d", i), {28'd0, mem_byteenable}, 32'h3);
            checkOutput($sformatf("store_noack_%0d", i), {30'd0, i_ack, d_ack}, 32'd0);
            if (i == 4) mem_waitrequest = 1'b0;
            tick();
        end
        checkOutput("store_ack", {30'd0, i_ack, d_ack}, 32'd1);
        checkOutput("store_rdata_kept", rdata, 32'h24020005);
        checkOutput("store_strobe_drop", {31'd0, mem_write}, 32'd0);
        idleInputs();
        tick();
        checkOutput("store_ack_pulse", {31'd0, d_ack}, 32'd0);

        // Read and write together is a write.
        $display("[TB] read+write collision");
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h00000040, 32'hCAFEF00D, 4'b1111);
        tick();
        checkOutput("rw_strobes", {30'd0, mem_write, mem_read}, 32'd2);
        checkOutput("rw_wdata", mem_writedata, 32'hCAFEF00D);
        tick();
        checkOutput("rw_ack", {31'd0, d_ack}, 32'd1);
        checkOutput("rw_rdata_kept", rdata, 32'h24020005);
        idleInputs();
        tick();

        // Ties from reset: fetch, then data, then fetch again.
        $display("[TB] round robin");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, 32'h00001000, 1'b1, 1'b0, 32'h00002000, 32'd0, 4'b0101);
        mem_readdata = 32'hAAAA0001;
        tick();
        checkOutput("rr1_addr", mem_address, 32'h00001000);
        checkOutput("rr1_be", {28'd0, mem_byteenable}, 32'hF);
        tick();
        checkOutput("rr1_ack", {30'd0, i_ack, d_ack}, 32'd2);
        checkOutput("rr1_rdata", rdata, 32'hAAAA0001);
        mem_readdata = 32'hBBBB0002;
        tick();
        tick();
        checkOutput("rr2_addr", mem_address, 32'h00002000);
        checkOutput("rr2_be", {28'd0, mem_byteenable}, 32'h5);
        checkOutput("rr2_read", {31'd0, mem_read}, 32'd1);
        tick();
        checkOutput("rr2_ack", {30'd0, i_ack, d_ack}, 32'd1);
        checkOutput("rr2_rdata", rdata, 32'hBBBB0002);
        mem_readdata = 32'hCCCC0003;
        tick();
        tick();
        checkOutput("rr3_addr", mem_address, 32'h00001000);
        tick();
        checkOutput("rr3_ack", {30'd0, i_ack, d_ack}, 32'd2);
        checkOutput("rr3_rdata", rdata, 32'hCCCC0003);
        idleInputs();
        tick();

        // Reset in the middle of a stalled transfer.
        $display("[TB] reset mid-transfer");
        applyStimulus(1'b1, 32'h00003000, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        mem_waitrequest = 1'b1;
        tick();
        checkOutput("mid_read", {31'd0, mem_read}, 32'd1);
        reset = 1'b1;
        #1;
        checkAllZero("mid_reset");
        idleInputs();
        tick();
        reset = 1'b0;
        mem_waitrequest = 1'b0;
        tick();
        checkOutput("mid_no_ack1", {30'd0, i_ack, d_ack}, 32'd0);
        tick();
        checkOutput("mid_no_ack2", {30'd0, i_ack, d_ack}, 32'd0);
        applyStimulus(1'b1, 32'h00003004, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        mem_readdata = 32'h12345678;
        tick();
        checkOutput("post_reset_addr", mem_address, 32'h00003004);
        tick();
        checkOutput("post_reset_ack", {30'd0, i_ack, d_ack}, 32'd2);
        checkOutput("post_reset_rdata", rdata, 32'h12345678);
        idleInputs();
        tick();

        // Clock enable low while a data read is outstanding.
        $display("[TB] clock enable freeze");
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h00000080, 32'd0, 4'b1000);
        mem_waitrequest = 1'b1;
        mem_readdata    = 32'h0BADF00D;
        tick();
        clk_enable      = 1'b0;
        mem_waitrequest = 1'b0;
        d_address       = 32'h00000090;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("freeze_read_%0d", i), {31'd0, mem_read}, 32'd1);
            checkOutput($sformatf("freeze_addr_%0d", i), mem_address, 32'h00000080);
            checkOutput($sformatf("freeze_noack_%0d", i), {31'd0, d_ack}, 32'd0);
        end
        clk_enable = 1'b1;
        tick();
        checkOutput("freeze_ack", {30'd0, i_ack, d_ack}, 32'd1);
        checkOutput("freeze_rdata", rdata, 32'h0BADF00D);
        idleInputs();
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // Stuck bus with a four-cycle limit: abort with err and zero data.
        $display("[TB] stall timeout");
        applyStimulus(1'b1, 32'h00004000, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        mem_waitrequest = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("to_read_%0d", i), {31'd0, mem_read}, 32'd1);
            checkOutput($sformatf("to_noack_%0d", i), {31'd0, i_ack}, 32'd0);
            tick();
        end
        checkOutput("to_strobe_drop", {31'd0, mem_read}, 32'd0);
        checkOutput("to_ack", {30'd0, i_ack, d_ack}, 32'd2);
        checkOutput("to_err", {31'd0, err}, 32'd1);
        checkOutput("to_rdata", rdata, 32'd0);
        idleInputs();
        mem_waitrequest = 1'b0;
        tick();
        checkOutput("to_err_clear", {31'd0, err}, 32'd0);
`else
        // Without the watchdog a stalled transfer waits as long as it takes.
        $display("[TB] long stall");
        applyStimulus(1'b1, 32'h00004000, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        mem_waitrequest = 1'b1;
        mem_readdata    = 32'h77778888;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        checkOutput("stall_read", {31'd0, mem_read}, 32'd1);
        checkOutput("stall_noack", {31'd0, i_ack}, 32'd0);
        mem_waitrequest = 1'b0;
        tick();
        checkOutput("stall_ack", {30'd0, i_ack, d_ack}, 32'd2);
        checkOutput("stall_err", {31'd0, err}, 32'd0);
        checkOutput("stall_rdata", rdata, 32'h77778888);
        idleInputs();
        tick();
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
